// File: rtl/tpu_pkg.sv
// Shared types and sizing helpers for the systolic matrix unit.
// Holds default array geometry and the memB sequencer state type.
package tpu_pkg;

    localparam int DEF_DIM     = 8;
    localparam int DEF_BITS_AB = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_READY = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } memb_state_t;

    function automatic int fill_w(input int dim);
        return $clog2(dim + 1);
    endfunction

    function automatic int drain_w(input int dim);
        return $clog2(2 * dim);
    endfunction

endpackage

// File: rtl/memb_seq.sv
// memB operand sequencer: loads DIM host rows into the memB FIFO bank,
// then drains it into the systolic array with zero fill behind the data.
module memb_seq
    import tpu_pkg::*;
#(
    parameter int BITS_AB = DEF_BITS_AB,
    parameter int DIM     = DEF_DIM
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic signed [BITS_AB-1:0] wr_row   [DIM-1:0],
    input  logic                      start,
    output logic                      memb_en,
    output logic signed [BITS_AB-1:0] memb_din [DIM-1:0],
    output logic                      sys_en,
    output logic [fill_w(DIM)-1:0]    fill_cnt,
    output logic                      busy,
    output logic                      done
);

    localparam int FW = fill_w(DIM);
    localparam int DW = drain_w(DIM);

    localparam logic [FW-1:0] FLAST = FW'(DIM);
    localparam logic [DW-1:0] DLAST = DW'(2 * DIM - 2);

    memb_state_t   state;
    memb_state_t   state_nx;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_nx;
    logic [FW-1:0] fcnt_nx;
    logic          accept;

    // wr_ready is only ever high in IDLE/FILL, so it doubles as the state gate
    assign accept = wr_valid && wr_ready && !clr;

    always_comb begin
        state_nx = state;
        fcnt_nx  = fill_cnt;
        dcnt_nx  = dcnt;
        if (clr) begin
            state_nx = ST_IDLE;
            fcnt_nx  = '0;
            dcnt_nx  = '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_FILL: begin
                    if (accept) begin
                        fcnt_nx  = fill_cnt + FW'(1);
                        state_nx = (fcnt_nx == FLAST) ? ST_READY : ST_FILL;
                    end
                end
                ST_READY: begin
                    if (start) begin
                        state_nx = ST_DRAIN;
                        dcnt_nx  = '0;
                    end
                end
                ST_DRAIN: begin
                    if (dcnt == DLAST) begin
                        state_nx = ST_DONE;
                    end else begin
                        dcnt_nx = dcnt + DW'(1);
                    end
                end
                ST_DONE: begin
                    state_nx = ST_IDLE;
                    fcnt_nx  = '0;
                end
                default: begin
                    state_nx = ST_IDLE;
                    fcnt_nx  = '0;
                    dcnt_nx  = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fill_cnt <= '0;
            dcnt     <= '0;
            wr_ready <= 1'b0;
            memb_en  <= 1'b0;
            sys_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                memb_din[i] <= '0;
            end
        end else begin
            state    <= state_nx;
            fill_cnt <= fcnt_nx;
            dcnt     <= dcnt_nx;
            wr_ready <= state_nx inside {ST_IDLE, ST_FILL};
            busy     <= state_nx inside {ST_FILL, ST_READY, ST_DRAIN};
            sys_en   <= state_nx == ST_DRAIN;
            memb_en  <= accept || (state_nx == ST_DRAIN);
            done     <= state_nx == ST_DONE;
            for (int i = 0; i < DIM; i++) begin
                memb_din[i] <= accept ? wr_row[i] : '0;
            end
        end
    end

endmodule

// File: tb/tb_memb_seq.sv
// Directed/random bench for memb_seq with a downstream memB shift model.
// Expected values come from fill/drain rules, not from the RTL structure.
module tb_memb_seq;

    localparam int DIM     = 8;
    localparam int BITS_AB = 8;

    typedef logic signed [BITS_AB-1:0] row_t [DIM-1:0];

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       wr_valid;
    logic       wr_ready;
    row_t       wr_row;
    logic       start;
    logic       memb_en;
    row_t       memb_din;
    logic       sys_en;
    logic [3:0] fill_cnt;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    row_t rows [DIM];
    row_t mb   [DIM];

    memb_seq #(
        .BITS_AB(BITS_AB),
        .DIM    (DIM)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_row  (wr_row),
        .start   (start),
        .memb_en (memb_en),
        .memb_din(memb_din),
        .sys_en  (sys_en),
        .fill_cnt(fill_cnt),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memB FIFO bank: shifts in on en, Bout is the oldest stage
    always @(posedge clk) begin
        if (memb_en) begin
            for (int i = DIM - 1; i > 0; i--) mb[i] <= mb[i-1];
            mb[0] <= memb_din;
        end
    end

    function automatic logic [63:0] pk(input row_t r);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < DIM; c++) v[c*BITS_AB +: BITS_AB] = r[c];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rows(input bit rnd);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                rows[r][c] = rnd ? 8'($urandom) : 8'(r * 8 + c);
    endtask

    task automatic fill(input int gap, input int start_at);
        for (int r = 0; r < DIM; r++) begin
            for (int g = 0; g < gap; g++) begin
                wr_valid = 1'b0;
                start    = 1'b0;
                tick();
                chk("gap_en", 64'(memb_en), 64'd0);
                chk("gap_cnt", 64'(fill_cnt), 64'(r));
            end
            wr_valid = 1'b1;
            wr_row   = rows[r];
            start    = (r == start_at);
            tick();
            chk("fill_en", 64'(memb_en), 64'd1);
            chk("fill_din", pk(memb_din), pk(rows[r]));
            chk("fill_cnt", 64'(fill_cnt), 64'(r + 1));
            chk("fill_rdy", 64'(wr_ready), 64'(r + 1 < DIM));
            chk("fill_busy", 64'(busy), 64'd1);
            chk("fill_sys", 64'(sys_en), 64'd0);
        end
        wr_valid = 1'b0;
        start    = 1'b0;
        tick();
        chk("ready_en", 64'(memb_en), 64'd0);
        chk("ready_sys", 64'(sys_en), 64'd0);
        chk("ready_rdy", 64'(wr_ready), 64'd0);
        for (int r = 0; r < DIM; r++)
            chk("memb_row", pk(mb[DIM-1-r]), pk(rows[r]));
    endtask

    task automatic drain(input int abort_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 2 * DIM; k++) begin
            chk("drn_en", 64'(memb_en), 64'd1);
            chk("drn_sys", 64'(sys_en), 64'd1);
            chk("drn_din", pk(memb_din), 64'd0);
            chk("drn_done", 64'(done), 64'd0);
            chk("drn_busy", 64'(busy), 64'd1);
            if (k <= DIM) chk("bout", pk(mb[DIM-1]), pk(rows[k-1]));
            else          chk("bout0", pk(mb[DIM-1]), 64'd0);
            if (k == abort_at) begin
                clr = 1'b1;
                tick();
                clr = 1'b0;
                chk("clr_en", 64'(memb_en), 64'd0);
                chk("clr_sys", 64'(sys_en), 64'd0);
                chk("clr_busy", 64'(busy), 64'd0);
                chk("clr_cnt", 64'(fill_cnt), 64'd0);
                chk("clr_rdy", 64'(wr_ready), 64'd1);
                repeat (2 * DIM) begin
                    tick();
                    chk("clr_nodone", 64'(done), 64'd0);
                    chk("clr_noen", 64'(memb_en), 64'd0);
                end
                return;
            end
            tick();
        end
        chk("done_hi", 64'(done), 64'd1);
        chk("done_en", 64'(memb_en), 64'd0);
        chk("done_sys", 64'(sys_en), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
        tick();
        chk("post_done", 64'(done), 64'd0);
        chk("post_cnt", 64'(fill_cnt), 64'd0);
        chk("post_rdy", 64'(wr_ready), 64'd1);
        chk("post_busy", 64'(busy), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, 64'(memb_en), 64'd0);
        chk({tag, "_sys"}, 64'(sys_en), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_rdy"}, 64'(wr_ready), 64'd0);
        chk({tag, "_cnt"}, 64'(fill_cnt), 64'd0);
        chk({tag, "_din"}, pk(memb_din), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        wr_valid = 1'b0;
        start    = 1'b0;
        for (int c = 0; c < DIM; c++) wr_row[c] = '0;

        tick();
        chk_zero("rst");
        #2 rst_n = 1'b1;
        tick();
        chk("rel_rdy", 64'(wr_ready), 64'd1);
        chk("rel_busy", 64'(busy), 64'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_start_busy", 64'(busy), 64'd0);
        chk("idle_start_sys", 64'(sys_en), 64'd0);
        chk("idle_start_en", 64'(memb_en), 64'd0);

        clr      = 1'b1;
        wr_valid = 1'b1;
        tick();
        clr      = 1'b0;
        wr_valid = 1'b0;
        chk("clrwr_en", 64'(memb_en), 64'd0);
        chk("clrwr_cnt", 64'(fill_cnt), 64'd0);

        set_rows(1'b0);
        fill(0, DIM - 1);
        drain(0);

        fill(2, 3);
        wr_valid = 1'b1;
        for (int c = 0; c < DIM; c++) wr_row[c] = 8'($urandom);
        tick();
        wr_valid = 1'b0;
        chk("extra_en", 64'(memb_en), 64'd0);
        chk("extra_cnt", 64'(fill_cnt), 64'(DIM));
        chk("extra_busy", 64'(busy), 64'd1);
        chk("extra_row0", pk(mb[DIM-1]), pk(rows[0]));
        drain(0);

        set_rows(1'b1);
        fill(1, -1);
        drain(5);

        set_rows(1'b1);
        fill(0, -1);
        drain(0);

        set_rows(1'b1);
        fill(0, -1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("pre_rst_en", 64'(memb_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst2_rdy", 64'(wr_ready), 64'd1);
        chk("rst2_cnt", 64'(fill_cnt), 64'd0);

        set_rows(1'b1);
        fill(0, -1);
        drain(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
